// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int BUS_DEF     = 32;
   localparam int MEMSIZE_DEF = 4096;

   typedef enum logic {M0 = 1'b0, M1 = 1'b1} req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t who;
      logic    err;
      logic    is_read;
   } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester preferred on a tie.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_id_t ptr_reg;

   // Grants are held off while reset is asserted, even if requests are high.
   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         if (req[0] && req[1]) begin
            gnt = (ptr_reg == M0) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= M0;
      end else if (gnt[0]) begin
         ptr_reg <= M1;
      end else if (gnt[1]) begin
         ptr_reg <= M0;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto the single-port data memory and returns
// one response per granted access in the following cycle.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int BUS     = BUS_DEF,
   parameter int MEMSIZE = MEMSIZE_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           m0_req,
   input  logic           m0_we,
   input  logic [BUS-1:0] m0_addr,
   input  logic [BUS-1:0] m0_wdata,
   output logic           m0_gnt,
   output logic           m0_rsp,
   output logic           m0_err,
   output logic [BUS-1:0] m0_rdata,
   input  logic           m1_req,
   input  logic           m1_we,
   input  logic [BUS-1:0] m1_addr,
   input  logic [BUS-1:0] m1_wdata,
   output logic           m1_gnt,
   output logic           m1_rsp,
   output logic           m1_err,
   output logic [BUS-1:0] m1_rdata,
   output logic [BUS-1:0] mem_datain,
   output logic [BUS-1:0] mem_writedir,
   output logic [BUS-1:0] mem_readdir,
   input  logic [BUS-1:0] mem_dataout,
   output logic           mem_mre,
   output logic           mem_mwe
);

   localparam logic [BUS-3:0] MEM_WORDS = (BUS-2)'(MEMSIZE);

   logic [1:0]     gnt;
   logic           granted;
   logic           sel_we;
   logic [BUS-1:0] sel_addr;
   logic [BUS-1:0] sel_wdata;
   logic           in_range;
   logic [BUS-1:0] last_addr_reg;
   logic [BUS-1:0] last_wdata_reg;
   logic [BUS-1:0] rsp_data;
   rsp_t           rsp_reg;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({m1_req, m0_req}),
      .gnt   (gnt)
   );

   assign m0_gnt   = gnt[0];
   assign m1_gnt   = gnt[1];
   assign granted  = |gnt;
   assign sel_we   = gnt[1] ? m1_we    : m0_we;
   assign sel_addr = gnt[1] ? m1_addr  : m0_addr;
   assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
   assign in_range = (sel_addr[BUS-1:2] < MEM_WORDS);

   // The memory indexes writes by readdir, so both address buses always match.
   assign mem_readdir  = granted ? sel_addr  : last_addr_reg;
   assign mem_writedir = mem_readdir;
   assign mem_datain   = granted ? sel_wdata : last_wdata_reg;
   assign mem_mre      = granted && in_range && !sel_we;
   assign mem_mwe      = granted && in_range && sel_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_addr_reg  <= '0;
         last_wdata_reg <= '0;
         rsp_reg        <= '0;
      end else begin
         if (granted) begin
            last_addr_reg  <= sel_addr;
            last_wdata_reg <= sel_wdata;
         end
         rsp_reg.valid   <= granted;
         rsp_reg.who     <= gnt[1] ? M1 : M0;
         rsp_reg.err     <= !in_range;
         rsp_reg.is_read <= !sel_we;
      end
   end

   assign rsp_data = (rsp_reg.is_read && !rsp_reg.err) ? mem_dataout : '0;
   assign m0_rsp   = rsp_reg.valid && (rsp_reg.who == M0);
   assign m1_rsp   = rsp_reg.valid && (rsp_reg.who == M1);
   assign m0_err   = m0_rsp && rsp_reg.err;
   assign m1_err   = m1_rsp && rsp_reg.err;
   assign m0_rdata = m0_rsp ? rsp_data : '0;
   assign m1_rdata = m1_rsp ? rsp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: the driver queues expected responses, a monitor checks them.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rsp, m0_err, m1_gnt, m1_rsp, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_datain, mem_writedir, mem_readdir, mem_dataout;
   logic        mem_mre, mem_mwe;

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   tests  = 0;
   int   failed = 0;

   logic [31:0] mem [0:4095];

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rsp(m0_rsp), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rsp(m1_rsp), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_datain(mem_datain), .mem_writedir(mem_writedir), .mem_readdir(mem_readdir),
      .mem_dataout(mem_dataout), .mem_mre(mem_mre), .mem_mwe(mem_mwe)
   );

   // Memory model: registered read on posedge, write on negedge indexed by readdir.
   always @(posedge clk) if (mem_mre) mem_dataout <= mem[mem_readdir[13:2]];
   always @(negedge clk) if (mem_mwe) mem[mem_readdir[13:2]] <= mem_datain;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Checks the current cycle at negedge, queues its response, then advances.
   task automatic step(input logic [1:0] exp_gnt, input logic [31:0] exp_addr,
                       input logic exp_mre, input logic exp_mwe, input logic exp_err,
                       input logic [31:0] exp_rdata, input logic push);
      exp_t e;
      @(negedge clk);
      chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, exp_gnt});
      chk("mem_mre", {31'd0, mem_mre}, {31'd0, exp_mre});
      chk("mem_mwe", {31'd0, mem_mwe}, {31'd0, exp_mwe});
      if (exp_gnt != 2'b00) begin
         chk("mem_readdir", mem_readdir, exp_addr);
         chk("mem_writedir", mem_writedir, exp_addr);
      end
      $display("[TB] t=%0t gnt=%b addr=%h mre=%b mwe=%b", $time, {m1_gnt, m0_gnt},
               mem_readdir, mem_mre, mem_mwe);
      if (push) begin
         e.port  = exp_gnt[1];
         e.err   = exp_err;
         e.rdata = exp_rdata;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (m0_rsp || m1_rsp)) begin
            chk("rsp_onehot", {31'd0, m0_rsp & m1_rsp}, 32'd0);
            if (sb_q.size() == 0) begin
               chk("rsp_unexpected", {30'd0, m1_rsp, m0_rsp}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_port", {30'd0, m1_rsp, m0_rsp}, e.port ? 32'd2 : 32'd1);
               chk("rsp_err", {31'd0, e.port ? m1_err : m0_err}, {31'd0, e.err});
               chk("rsp_rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
               chk("idle_rdata", e.port ? m0_rdata : m1_rdata, 32'd0);
               $display("[TB] t=%0t rsp port=%0d err=%b rdata=%h", $time, e.port,
                        e.port ? m1_err : m0_err, e.port ? m1_rdata : m0_rdata);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[0] = 32'h1111_0000;
      mem[1] = 32'h2222_0001;
      rst_n = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
      @(negedge clk);
      chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("rst_mre", {31'd0, mem_mre}, 32'd0);
      chk("rst_rsp", {30'd0, m1_rsp, m0_rsp}, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      @(posedge clk); #1;
      m0_req = 1'b0;
      rst_n  = 1'b1;

      // Alternating reads with both requesting, pointer starts at M0.
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
      for (int i = 0; i < 3; i++) begin
         step(2'b01, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1111_0000, 1'b1);
         step(2'b10, 32'h4, 1'b1, 1'b0, 1'b0, 32'h2222_0001, 1'b1);
      end

      // Write then read back the same word.
      m1_req = 1'b0;
      m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
      step(2'b01, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      m0_we = 1'b0;
      step(2'b01, 32'h10, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);

      // Write by m0, immediate read of the same word by m1.
      m0_we = 1'b1; m0_addr = 32'h8; m0_wdata = 32'hCAFE_0008;
      step(2'b01, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      m0_req = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
      step(2'b10, 32'h8, 1'b1, 1'b0, 1'b0, 32'hCAFE_0008, 1'b1);

      // Out-of-range write then read: granted, no strobe, error response.
      m1_we = 1'b1; m1_addr = 32'h4000; m1_wdata = 32'h5555_5555;
      step(2'b10, 32'h4000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      m1_req = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4000;
      step(2'b01, 32'h4000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);

      // Last in-range word still accepted.
      m0_addr = 32'h3FFC;
      step(2'b01, 32'h3FFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // m1 alone three times, then a tie goes to m0, then to m1.
      m0_req = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
      for (int i = 0; i < 3; i++) step(2'b10, 32'h4, 1'b1, 1'b0, 1'b0, 32'h2222_0001, 1'b1);
      m0_req = 1'b1; m0_addr = 32'h0;
      step(2'b01, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1111_0000, 1'b1);
      step(2'b10, 32'h4, 1'b1, 1'b0, 1'b0, 32'h2222_0001, 1'b1);
      m0_req = 1'b0; m1_req = 1'b0;
      step(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      // m0 read granted (pointer moves to M1), reset before its response.
      m0_req = 1'b1; m0_addr = 32'h10;
      step(2'b01, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      m0_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_rsp", {30'd0, m1_rsp, m0_rsp}, 32'd0);
      chk("rstmid_strobes", {30'd0, mem_mwe, mem_mre}, 32'd0);
      #1 rst_n = 1'b1;
      step(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      m0_req = 1'b1; m0_addr = 32'h0;
      m1_req = 1'b1; m1_addr = 32'h4;
      step(2'b01, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1111_0000, 1'b1);
      m0_req = 1'b0; m1_req = 1'b0;
      step(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory. Grants one access per cycle to either the CPU load/store unit (m0) or the loader/debug port (m1) using round-robin, drives the memory's read/write strobes and address buses, range-checks addresses, and returns exactly one response per granted access. It sits between the execute/memory stage and the data memory instance.

## Interface

- BUS, 32, data and address width
- MEMSIZE, 4096, memory depth in words; word index is addr[BUS-1:2]

- clk  in  1  system clock; memory reads on posedge, writes on negedge
- rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request; held with its payload until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  BUS  byte address
- m0_wdata / m1_wdata  in  BUS  write data
- m0_gnt / m1_gnt  out  1  combinational; request accepted this cycle
- m0_rsp / m1_rsp  out  1  one-cycle response pulse, cycle after grant
- m0_err / m1_err  out  1  valid with rsp; address out of range
- m0_rdata / m1_rdata  out  BUS  read data, valid with rsp for reads
- mem_datain  out  BUS  to memory datain
- mem_writedir  out  BUS  to memory writedir
- mem_readdir  out  BUS  to memory readdir
- mem_dataout  in  BUS  from memory dataout
- mem_mre  out  1  memory read enable
- mem_mwe  out  1  memory write enable

## Operation

- Arbitration: rr pointer (1 bit) names the preferred requester. Both requesting -> preferred wins; one requesting -> it wins. After any grant, pointer = the other requester. No grant when neither requests.
- At most one gnt per cycle; gnt only with matching req.
- Issue (grant cycle N): mem_readdir and mem_writedir both driven with the granted addr, identical every cycle (the memory indexes writes by readdir). mem_datain = granted wdata. Range check: in_range = (addr[BUS-1:2] < MEMSIZE).
- Read, in range: mem_mre = 1 in N. Write, in range: mem_mwe = 1 in N.
- Out of range: gnt still given, mem_mre = mem_mwe = 0, err reported.
- No grant: mem_mre = mem_mwe = 0; address/data buses drive last granted values (don't-care for verification).
- Response register: rsp_who, rsp_valid, rsp_err, rsp_is_read captured at posedge ending N. In N+1: mX_rsp = 1 for the granted requester only; mX_err = rsp_err; mX_rdata = mem_dataout when rsp_is_read and !rsp_err, else 0.
- Writes respond with rsp=1, rdata=0. Non-responding port drives rsp=0, err=0, rdata=0.
- Back-to-back: new grant allowed in N+1 while response for N is out; full throughput one access/cycle.

## Timing

- Reset (rst_n=0, async): pointer = m0; rsp_valid = 0; all rsp/err = 0, rdata = 0; mem_mre = mem_mwe = 0 once req inputs low (gnt is combinational but forced 0 during reset).
- Reset asserted between grant and response: response dropped, no rsp pulse after release.
- Read latency: gnt in N -> rsp + rdata in N+1.
- Write commit: negedge inside N; a read of the same word granted in N+1 returns the new data.
- Simultaneous requests every cycle: grants alternate m0, m1, m0, … starting from pointer value.
- Requester dropping req before gnt: legal, no access issued.

## Structure

- Package dmem_arb_pkg: typedef enum logic {M0, M1} req_id_t; response struct (valid, who, err, is_read); default BUS/MEMSIZE localparams.
- Sub-module rr_arb2: 2-input round-robin arbiter (req[1:0], pointer register, gnt[1:0]), reset to M0 preference.
- Top: mux, range check, strobe generation, response register, response demux.

## Test plan

- Reset then m0 write 0xDEADBEEF @0x10, next cycle m0 read @0x10 -> m0_rsp in both N+1 slots, read rdata = 0xDEADBEEF, err=0.
- Both req continuously (m0 reads @0x0, m1 reads @0x4) for 6 cycles -> grants M0,M1,M0,M1,M0,M1; each rsp to correct port next cycle with its own data.
- m1 write @0x4000 (word 4096, MEMSIZE=4096) -> m1_gnt=1, mem_mwe=0, m1_rsp=1 and m1_err=1 next cycle; read @0x4000 later returns err, rdata=0.
- Only m1 requesting for 3 cycles, then both -> m1 granted thrice, then m0 wins tie (pointer = M0).
- Read granted, rst_n pulsed low mid-cycle before response -> no rsp after release, pointer = M0, strobes 0.
- m0 write @0x8 in N, m1 read @0x8 in N+1 -> m1 rdata = written value.
